id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RISC-V core.
- Captures the Controller's control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, Jump) plus the decoded operands, and presents them to the EX stage one cycle later.
- Contains the load-use hazard detector:
  - inserts a bubble on a hazard;
  - tells fetch/decode to stall;
  - honours flush (branch/jump redirect) and downstream hold.

Parameters:
- DATA_W, 32, width of register operands and immediate.
- PC_W, 9, width of the program counter.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- id_valid  in  1  decode slot holds a real instruction.
- id_opcode  in  7  opcode of the decode instruction; used only for hazard operand-use decode.
- id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  Controller outputs.
- id_ALUOp  in  2  Controller ALUOp.
- id_pc  in  PC_W  PC of the decode instruction.
- id_rd1, id_rd2  in  DATA_W  register file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_funct3  in  3  funct3 field.
- id_funct7  in  7  funct7 field.
- flush  in  1  squash the instruction entering EX (taken branch/jump).
- hold_in  in  1  EX cannot accept; freeze the register.
- ex_* outputs  out  widths matching the id_* inputs  registered copies of every id_* field above except id_opcode.
- ex_valid  out  1  EX slot holds a real instruction.
- stall_out  out  1  combinational; freeze PC and the IF/ID register this cycle.
- bubble_cnt  out  CNT_W  number of bubbles inserted by load-use hazards, saturating.

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output, ex_valid and bubble_cnt go to 0. Outputs stay 0 until the first rising edge after reset returns to 1.
- Operand use, decoded from id_opcode:
  - rs1 is used by 0110011, 0000011, 0100011, 1100011, 0010011 and 1100111.
  - rs2 is used by 0110011, 0100011 and 1100011.
  - Any other opcode uses neither.
- Hazard (combinational), asserted when all of the following hold:
  - ex_valid & ex_MemRead & (ex_rd != 0) & id_valid;
  - and either (ex_rd == id_rs1 & rs1 used) or (ex_rd == id_rs2 & rs2 used).
- stall_out = hold_in | (hazard & ~flush).
- Register update at each rising edge, in priority order:
  1. flush=1 → load a bubble.
  2. else hold_in=1 → all registers keep their value.
  3. else hazard=1 → load a bubble, and increment bubble_cnt if it is below 2^CNT_W-1.
  4. else → load all id_* fields. ex_valid gets id_valid. If id_valid=0, all control outputs load 0.
- Bubble definition: ex_valid=0; every control output 0 (ALUOp=00); all data and index outputs 0.
- Latency: exactly one cycle from id_* to ex_*, when not held.
- A bubble never causes a write. RegWrite, MemWrite, MemRead, Branch and Jump are always 0 whenever ex_valid=0.
- Only a hazard bubble counts toward bubble_cnt. A flush bubble does not count. bubble_cnt never wraps: it holds at all-ones.
- A load-use hazard inserts exactly one bubble. After that edge ex_MemRead=0, so the hazard clears and the stalled instruction enters EX on the next edge.
- flush together with hazard: flush wins. stall_out=0, a bubble is loaded, and the counter does not change.
- flush together with hold_in: a bubble is loaded and stall_out=1.
- Reset asserted mid-stall or mid-flush: everything clears immediately, with no pending state.

Test Plan:
- Reset: hold reset=0 with random id_* inputs → all ex_* outputs 0, ex_valid=0, bubble_cnt=0, and no change on clock edges. Release reset → first edge loads id_*.
- Pass-through: id_opcode=0110011, id_RegWrite=1, id_ALUOp=10, id_rd1=0x11, id_rd2=0x22, id_rd=5, id_valid=1 → next cycle ex_RegWrite=1, ex_ALUOp=10, ex_rd1=0x11, ex_rd2=0x22, ex_rd=5, ex_valid=1, stall_out=0.
- Load-use on rs1:
  - EX holds a LW with ex_rd=7; ID holds an ADDI (opcode 0010011) with id_rs1=7.
  - → stall_out=1, next cycle all ex_* control 0 and ex_valid=0, bubble_cnt=1.
  - On the following edge the ADDI enters EX with stall_out=0.
- No hazard:
  - EX holds a LW with ex_rd=0 while id_rs1=0 → stall_out=0, no bubble.
  - EX holds a LW with ex_rd=3; ID holds a JAL (opcode 1101111) with id_rs1=3 → stall_out=0, no bubble.
- Flush priority: hazard condition present and flush=1 → stall_out=0, next cycle ex_valid=0, bubble_cnt unchanged.
- Hold and saturation:
  - hold_in=1 for 3 cycles → ex_* outputs stay stable and stall_out=1.
  - With CNT_W=2, force 5 hazards → bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with load-use hazard detection
//
// Purpose:
//   Registers the Controller's control bundle and the decoded operands
//   between the ID and EX stages. Detects load-use hazards against the
//   load currently in EX, inserts one bubble per hazard, and requests a
//   fetch/decode stall. Flush squashes the instruction entering EX, and
//   hold_in freezes the whole register.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   id_valid, id_opcode  decode slot valid flag and opcode (hazard decode only)
//   id_<ctrl>            ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//                        Branch, Jump, ALUOp from the Controller
//   id_<data>            pc, rd1, rd2, imm, rs1, rs2, rd, funct3, funct7
//   flush, hold_in       redirect squash and downstream back-pressure
//   ex_*                 registered copies of the id_* fields (not opcode)
//   ex_valid             EX slot holds a real instruction
//   stall_out            combinational freeze request for PC and IF/ID
//   bubble_cnt           saturating count of load-use bubbles
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              id_Jump,
    input  logic [1:0]        id_ALUOp,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    input  logic              hold_in,
    output logic              ex_valid,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic              ex_Jump,
    output logic [1:0]        ex_ALUOp,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic use_rs1;
    logic use_rs2;
    logic hazard;
    logic load_en;
    logic bubble;
    logic ctrl_kill;
    logic cnt_inc;

    // Which source registers the decode instruction actually reads.
    // U-type, JAL and system opcodes read neither, so they never stall.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end  // R-type
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end  // store
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end  // branch
            7'b0000011: use_rs1 = 1'b1;                             // load
            7'b0010011: use_rs1 = 1'b1;                             // OP-IMM
            7'b1100111: use_rs1 = 1'b1;                             // JALR
            default: ;
        endcase
    end

    assign hazard = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
                    (((ex_rd == id_rs1) & use_rs1) | ((ex_rd == id_rs2) & use_rs2));

    // A squashed instruction cannot be the victim of a hazard, so flush
    // masks the hazard part of the stall; hold always freezes upstream.
    assign stall_out = hold_in | (hazard & ~flush);

    // Flush overrides hold; otherwise hold freezes everything.
    assign load_en   = flush | ~hold_in;
    assign bubble    = flush | hazard;
    assign ctrl_kill = bubble | ~id_valid;
    assign cnt_inc   = ~flush & ~hold_in & hazard & (bubble_cnt != {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_pc       <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            bubble_cnt  <= '0;
        end else begin
            if (load_en) begin
                ex_valid    <= id_valid & ~bubble;
                ex_ALUSrc   <= id_ALUSrc   & ~ctrl_kill;
                ex_MemtoReg <= id_MemtoReg & ~ctrl_kill;
                ex_RegWrite <= id_RegWrite & ~ctrl_kill;
                ex_MemRead  <= id_MemRead  & ~ctrl_kill;
                ex_MemWrite <= id_MemWrite & ~ctrl_kill;
                ex_Branch   <= id_Branch   & ~ctrl_kill;
                ex_Jump     <= id_Jump     & ~ctrl_kill;
                ex_ALUOp    <= ctrl_kill ? 2'b00 : id_ALUOp;
                // Data fields of an invalid slot still pass through; only
                // a bubble zeroes them.
                ex_pc       <= bubble ? '0 : id_pc;
                ex_rd1      <= bubble ? '0 : id_rd1;
                ex_rd2      <= bubble ? '0 : id_rd2;
                ex_imm      <= bubble ? '0 : id_imm;
                ex_rs1      <= bubble ? '0 : id_rs1;
                ex_rs2      <= bubble ? '0 : id_rs2;
                ex_rd       <= bubble ? '0 : id_rd;
                ex_funct3   <= bubble ? '0 : id_funct3;
                ex_funct7   <= bubble ? '0 : id_funct7;
            end
            if (cnt_inc) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a reference model
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int PW = 9;
    localparam int CW = 3;

    typedef struct packed {
        logic          rstn, flush, hold, valid;
        logic [6:0]    op;
        logic          alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
        logic [1:0]    aluop;
        logic [PW-1:0] pc;
        logic [DW-1:0] rd1, rd2, imm;
        logic [4:0]    rs1, rs2, rd;
        logic [2:0]    f3;
        logic [6:0]    f7;
    } in_t;

    typedef struct packed {
        logic          valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
        logic [1:0]    aluop;
        logic [PW-1:0] pc;
        logic [DW-1:0] rd1, rd2, imm;
        logic [4:0]    rs1, rs2, rd;
        logic [2:0]    f3;
        logic [6:0]    f7;
        logic [CW-1:0] cnt;
    } st_t;

    typedef struct packed {
        logic stall;
        logic in_reset;
    } cmb_t;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump;
    logic [6:0] id_opcode, id_funct7;
    logic [1:0] id_ALUOp;
    logic [PW-1:0] id_pc;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_funct3;
    logic flush, hold_in;
    logic ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0] ex_ALUOp;
    logic [PW-1:0] ex_pc;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [6:0] ex_funct7;
    logic stall_out;
    logic [CW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    st_t  exp_q[$];
    cmb_t cmb_q[$];
    st_t  m;
    st_t  act;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
        .id_Jump(id_Jump), .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush), .hold_in(hold_in),
        .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .stall_out(stall_out),
        .bubble_cnt(bubble_cnt)
    );

    assign act = {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                  ex_Branch, ex_Jump, ex_ALUOp, ex_pc, ex_rd1, ex_rd2, ex_imm,
                  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, bubble_cnt};

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic in_t idle();
        in_t x = '0;
        x.rstn = 1'b1;
        x.valid = 1'b1;
        x.op = 7'b0010011;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        logic [6:0] ops [8];
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0010011, 7'b1100111, 7'b1101111, 7'b0110111};
        x = idle();
        x.rstn     = ($urandom_range(0, 59) != 0);
        x.flush    = ($urandom_range(0, 7) == 0);
        x.hold     = ($urandom_range(0, 5) == 0);
        x.valid    = ($urandom_range(0, 7) != 0);
        x.op       = ops[$urandom_range(0, 7)];
        x.alusrc   = 1'($urandom); x.memtoreg = 1'($urandom); x.regwrite = 1'($urandom);
        x.memread  = ($urandom_range(0, 2) == 0);
        x.memwrite = 1'($urandom); x.branch = 1'($urandom); x.jump = 1'($urandom);
        x.aluop    = 2'($urandom);
        x.pc       = PW'($urandom);
        x.rd1      = $urandom; x.rd2 = $urandom; x.imm = $urandom;
        x.rs1      = 5'($urandom_range(0, 5)); x.rs2 = 5'($urandom_range(0, 5));
        x.rd       = 5'($urandom_range(0, 5));
        x.f3       = 3'($urandom); x.f7 = 7'($urandom);
        return x;
    endfunction

    // One cycle: apply inputs at the falling edge, predict stall_out for this
    // cycle and the EX-slot contents after the next rising edge.
    task automatic drive(input in_t x);
        bit hz, st;
        logic [CW-1:0] c;
        @(negedge clk);
        reset = x.rstn; flush = x.flush; hold_in = x.hold; id_valid = x.valid;
        id_opcode = x.op; id_ALUSrc = x.alusrc; id_MemtoReg = x.memtoreg;
        id_RegWrite = x.regwrite; id_MemRead = x.memread; id_MemWrite = x.memwrite;
        id_Branch = x.branch; id_Jump = x.jump; id_ALUOp = x.aluop; id_pc = x.pc;
        id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm = x.imm; id_rs1 = x.rs1; id_rs2 = x.rs2;
        id_rd = x.rd; id_funct3 = x.f3; id_funct7 = x.f7;
        if (!x.rstn) m = '0;
        hz = m.valid && m.memread && m.rd != 0 && x.valid &&
             ((m.rd == x.rs1 && reads_rs1(x.op)) || (m.rd == x.rs2 && reads_rs2(x.op)));
        st = x.hold || (hz && !x.flush);
        c = m.cnt;
        if (x.rstn && (x.flush || (!x.hold && hz))) begin
            m = '0;
            m.cnt = (hz && !x.flush && c != {CW{1'b1}}) ? c + 1'b1 : c;
        end else if (x.rstn && !x.hold) begin
            m = '0;
            m.valid = x.valid;
            if (x.valid) begin
                m.alusrc = x.alusrc; m.memtoreg = x.memtoreg; m.regwrite = x.regwrite;
                m.memread = x.memread; m.memwrite = x.memwrite; m.branch = x.branch;
                m.jump = x.jump; m.aluop = x.aluop;
            end
            m.pc = x.pc; m.rd1 = x.rd1; m.rd2 = x.rd2; m.imm = x.imm;
            m.rs1 = x.rs1; m.rs2 = x.rs2; m.rd = x.rd; m.f3 = x.f3; m.f7 = x.f7;
            m.cnt = c;
        end
        cmb_q.push_back('{stall: st, in_reset: !x.rstn});
        exp_q.push_back(m);
    endtask

    // Combinational monitor: stall_out mid-cycle, and immediate clear under reset.
    initial begin
        cmb_t s;
        forever begin
            @(negedge clk);
            #2;
            if (cmb_q.size() > 0) begin
                s = cmb_q.pop_front();
                checks++;
                if (stall_out !== s.stall) begin
                    errors++;
                    $display("FAIL stall_out t=%0t got %b want %b", $time, stall_out, s.stall);
                end
                if (s.in_reset) begin
                    checks++;
                    if (act !== st_t'(0)) begin
                        errors++;
                        $display("FAIL async_reset t=%0t got %h want 0", $time, act);
                    end
                end
            end
        end
    end

    // Registered monitor: EX slot and counter after each rising edge.
    initial begin
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ex_state t=%0t got %h want %h", $time, act, e);
                end
            end
        end
    end

    initial begin
        in_t x, lw;
        m = '0;
        reset = 1'b0; flush = 1'b0; hold_in = 1'b0; id_valid = 1'b0; id_opcode = '0;
        id_ALUSrc = 0; id_MemtoReg = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
        id_Branch = 0; id_Jump = 0; id_ALUOp = '0; id_pc = '0; id_rd1 = '0; id_rd2 = '0;
        id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0; id_funct7 = '0;

        // Reset held with random inputs, then release.
        repeat (3) begin x = rnd(); x.rstn = 1'b0; drive(x); end
        x = rnd(); x.rstn = 1'b1; x.flush = 0; x.hold = 0; drive(x);

        // Pass-through of an R-type.
        x = idle(); x.op = 7'b0110011; x.regwrite = 1; x.aluop = 2'b10;
        x.rd1 = 32'h11; x.rd2 = 32'h22; x.rd = 5'd5; x.pc = 9'h40; drive(x);

        // Load-use on rs1: LW x7, then ADDI reading x7 stalls once.
        lw = idle(); lw.op = 7'b0000011; lw.memread = 1; lw.memtoreg = 1; lw.regwrite = 1;
        lw.alusrc = 1; lw.rd = 5'd7; lw.rs1 = 5'd1; drive(lw);
        x = idle(); x.op = 7'b0010011; x.rs1 = 5'd7; x.rd = 5'd8; x.regwrite = 1;
        drive(x); drive(x);

        // LW to x0 never creates a hazard.
        lw.rd = 5'd0; drive(lw);
        x.rs1 = 5'd0; drive(x);

        // JAL does not read rs1.
        lw.rd = 5'd3; drive(lw);
        x = idle(); x.op = 7'b1101111; x.rs1 = 5'd3; x.jump = 1; drive(x);

        // Flush wins over a hazard on rs2.
        lw.rd = 5'd4; drive(lw);
        x = idle(); x.op = 7'b0110011; x.rs2 = 5'd4; x.flush = 1; drive(x);

        // Hold for three cycles, then flush together with hold.
        drive(lw);
        x = rnd(); x.rstn = 1; x.flush = 0; x.hold = 1;
        repeat (3) drive(x);
        x.flush = 1; drive(x);

        // Saturation: more hazards than the counter can hold.
        repeat (10) begin
            lw.rd = 5'd2; drive(lw);
            x = idle(); x.op = 7'b0110011; x.rs1 = 5'd2; drive(x); drive(x);
        end

        // Reset asserted mid-stall.
        drive(lw);
        x = idle(); x.op = 7'b0110011; x.rs1 = 5'd2; x.rstn = 0; drive(x);

        // Randomized traffic.
        repeat (3000) drive(rnd());

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0 || cmb_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d want 0/0", exp_q.size(), cmb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
